// File: rtl/adder_4bit_if.sv
// Bit-level operand/sum bundle for adder_4bit. The master drives the operands and carry-in;
// the slave (the adder) returns the registered sum bits and carry-out.
interface adder_4bit_if;
   logic a1;
   logic a2;
   logic a3;
   logic a4;
   logic b1;
   logic b2;
   logic b3;
   logic b4;
   logic c;
   logic s1;
   logic s2;
   logic s3;
   logic s4;
   logic C;

   modport master (
      output a1, a2, a3, a4,
      output b1, b2, b3, b4,
      output c,
      input  s1, s2, s3, s4,
      input  C
   );

   modport slave (
      input  a1, a2, a3, a4,
      input  b1, b2, b3, b4,
      input  c,
      output s1, s2, s3, s4,
      output C
   );
endinterface

// File: rtl/adder_4bit.sv
// Registered 4-bit ripple-carry adder: {C,s4..s1} <= A + B + c, one cycle latency.
// Define ADDER_INPUT_REG_EN to add an input register stage (latency 2, reg-to-reg carry chain).
module adder_4bit (
   input  logic         clk,
   input  logic         rst_n,
   adder_4bit_if.slave  bus
);

   logic [3:0] w_a;
   logic [3:0] w_b;
   logic       w_cin;

`ifdef ADDER_INPUT_REG_EN
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic       r_cin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= 4'd0;
         r_b   <= 4'd0;
         r_cin <= 1'b0;
      end else begin
         r_a   <= {bus.a4, bus.a3, bus.a2, bus.a1};
         r_b   <= {bus.b4, bus.b3, bus.b2, bus.b1};
         r_cin <= bus.c;
      end
   end

   assign w_a   = r_a;
   assign w_b   = r_b;
   assign w_cin = r_cin;
`else
   assign w_a   = {bus.a4, bus.a3, bus.a2, bus.a1};
   assign w_b   = {bus.b4, bus.b3, bus.b2, bus.b1};
   assign w_cin = bus.c;
`endif

   // w_carry[i] is the carry into stage i; w_carry[4] is the carry-out.
   logic [4:0] w_carry;
   logic [3:0] w_sum;

   assign w_carry[0] = w_cin;

   for (genvar gi = 0; gi < 4; gi++) begin : g_stage
      logic w_p;
      assign w_p            = w_a[gi] ^ w_b[gi];
      assign w_sum[gi]      = w_p ^ w_carry[gi];
      assign w_carry[gi+1]  = (w_a[gi] & w_b[gi]) | (w_carry[gi] & w_p);
   end

   logic [3:0] r_sum;
   logic       r_cout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= 4'd0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= w_sum;
         r_cout <= w_carry[4];
      end
   end

   assign bus.s1 = r_sum[0];
   assign bus.s2 = r_sum[1];
   assign bus.s3 = r_sum[2];
   assign bus.s4 = r_sum[3];
   assign bus.C  = r_cout;

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: directed boundary cases, exhaustive sweep and random
// vectors checked against an arithmetic queue model delayed by the build's latency.
module tb_adder_4bit;

`ifdef ADDER_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   adder_4bit_if bus_if ();

   adder_4bit u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int q_exp[$];

   function automatic logic [4:0] obs();
      return {bus_if.C, bus_if.s4, bus_if.s3, bus_if.s2, bus_if.s1};
   endfunction

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
      {bus_if.a4, bus_if.a3, bus_if.a2, bus_if.a1} = a;
      {bus_if.b4, bus_if.b3, bus_if.b2, bus_if.b1} = b;
      bus_if.c = ci;
   endtask

   // Apply a vector, record A+B+c, advance one cycle and return what should now be visible.
   task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       output logic [4:0] exp);
      drive(a, b, ci);
      q_exp.push_back(int'(a) + int'(b) + int'(ci));
      @(posedge clk);
      @(negedge clk);
      if (q_exp.size() >= LAT) exp = 5'(q_exp[q_exp.size() - LAT]);
      else                     exp = 5'd0;
   endtask

   task automatic test_reset();
      logic [4:0] e;
      rst_n = 1'b0;
      drive(4'd9, 4'd6, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (obs() !== 5'd0) begin
            n_err++;
            $display("FAIL reset_hold cycle %0d: got %b expected 00000", i, obs());
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      q_exp.delete();
      for (int i = 0; i < LAT; i++) begin
         step(4'd9, 4'd6, 1'b1, e);
         n_cmp++;
         if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_release step %0d: got %b expected %b", i, obs(), e);
         end
      end
      n_cmp++;
      if (obs() !== 5'b10000) begin
         n_err++;
         $display("FAIL reset_first_result: got %b expected 10000", obs());
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs() !== 5'd0) begin
         n_err++;
         $display("FAIL reset_async_clear: got %b expected 00000", obs());
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs() !== 5'd0) begin
         n_err++;
         $display("FAIL reset_async_hold: got %b expected 00000", obs());
      end
      @(negedge clk);
      rst_n = 1'b1;
      q_exp.delete();
      step(4'd9, 4'd6, 1'b1, e);
      n_cmp++;
      if (obs() !== e) begin
         n_err++;
         $display("FAIL reset_no_replay: got %b expected %b", obs(), e);
      end
   endtask

   task automatic test_zero_carry();
      logic [4:0] e;
      for (int i = 0; i < LAT; i++) step(4'd0, 4'd0, 1'b1, e);
      n_cmp++;
      if (obs() !== 5'b00001) begin
         n_err++;
         $display("FAIL zero_carry: got %b expected 00001", obs());
      end
   endtask

   task automatic test_full_ripple();
      logic [4:0] e;
      for (int i = 0; i < LAT; i++) step(4'd15, 4'd0, 1'b1, e);
      n_cmp++;
      if (obs() !== 5'b10000) begin
         n_err++;
         $display("FAIL full_ripple: got %b expected 10000", obs());
      end
   endtask

   task automatic test_max();
      logic [4:0] e;
      for (int i = 0; i < LAT; i++) step(4'd15, 4'd15, 1'b1, e);
      n_cmp++;
      if (obs() !== 5'b11111) begin
         n_err++;
         $display("FAIL max_cin1: got %b expected 11111", obs());
      end
      for (int i = 0; i < LAT; i++) step(4'd15, 4'd15, 1'b0, e);
      n_cmp++;
      if (obs() !== 5'b11110) begin
         n_err++;
         $display("FAIL max_cin0: got %b expected 11110", obs());
      end
   endtask

   task automatic test_sweep();
      logic [4:0] e;
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int ci = 0; ci < 2; ci++) begin
               step(4'(a), 4'(b), 1'(ci), e);
               n_cmp++;
               if (obs() !== e) begin
                  n_err++;
                  $display("FAIL sweep a=%0d b=%0d c=%0d: got %b expected %b", a, b, ci, obs(), e);
               end
            end
   endtask

   task automatic test_back_to_back();
      logic [4:0] e;
      logic [4:0] pat;
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) step(4'd5, 4'd3, 1'b0, e);
         else            step(4'd8, 4'd8, 1'b1, e);
         n_cmp++;
         if (obs() !== e) begin
            n_err++;
            $display("FAIL b2b_model step %0d: got %b expected %b", i, obs(), e);
         end
         if (i >= LAT - 1) begin
            pat = ((i - (LAT - 1)) % 2 == 0) ? 5'b01000 : 5'b10001;
            n_cmp++;
            if (obs() !== pat) begin
               n_err++;
               $display("FAIL b2b_pattern step %0d: got %b expected %b", i, obs(), pat);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] e;
      logic [3:0] a, b;
      logic       ci;
      for (int i = 0; i < 200; i++) begin
         // A stray value between edges must be overwritten without effect.
         drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
         #2;
         a  = 4'($urandom_range(15));
         b  = 4'($urandom_range(15));
         ci = 1'($urandom_range(1));
         step(a, b, ci, e);
         n_cmp++;
         if (obs() !== e) begin
            n_err++;
            $display("FAIL random %0d a=%0d b=%0d c=%0d: got %b expected %b", i, a, b, ci, obs(), e);
         end
      end
   endtask

   initial begin
      drive(4'd0, 4'd0, 1'b0);
      test_reset();
      test_zero_carry();
      test_full_ripple();
      test_max();
      test_sweep();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
